// File: rtl/pattern_scan_ctrl_if.sv
// pattern_scan_ctrl_if: data-memory port shared with the core through a req/grant handshake
interface pattern_scan_ctrl_if #(parameter int AW = 8);
  logic          bus_req;
  logic          bus_gnt;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic [7:0]    mem_wdata;
  modport master (output bus_req, mem_addr, mem_we, mem_wdata, input bus_gnt, mem_rdata);
  modport slave  (input bus_req, mem_addr, mem_we, mem_wdata, output bus_gnt, mem_rdata);
endinterface

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: counts 5-bit pattern hits in a 32-byte message held in data memory
module pattern_scan_ctrl #(
  parameter int AW       = 8,
  parameter int NBYTES   = 32,
  parameter int PAT_ADDR = 32,
  parameter int RES_ADDR = 33
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done,
  pattern_scan_ctrl_if.master bus
);
  localparam int IW = $clog2(NBYTES);
  typedef enum logic [2:0] {IDLE, ARB, LDPAT, SCAN, WR0, WR1, WR2, DONE} state_t;
  state_t        state, nxt;
  logic [4:0]    pat;
  logic [IW-1:0] idx;
  logic [3:0]    prev4;
  logic [7:0]    ctb, cto, cts;
  logic [2:0]    in_hits;
  logic [3:0]    x_hits;
  logic [11:0]   w;
  logic          go;
  assign go = (state == IDLE || state == DONE) && start;
  assign w  = {prev4, bus.mem_rdata};
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = start ? ARB : state;
      ARB:        nxt = bus.bus_gnt ? LDPAT : ARB;
      LDPAT:      nxt = bus.bus_gnt ? SCAN : LDPAT;
      SCAN:       nxt = (bus.bus_gnt && idx == IW'(NBYTES - 1)) ? WR0 : SCAN;
      WR0:        nxt = bus.bus_gnt ? WR1 : WR0;
      WR1:        nxt = bus.bus_gnt ? WR2 : WR1;
      WR2:        nxt = bus.bus_gnt ? DONE : WR2;
      default:    nxt = IDLE;
    endcase
  end
  always_comb begin
    done          = state == DONE;
    bus.bus_req   = state inside {ARB, LDPAT, SCAN, WR0, WR1, WR2};
    bus.mem_we    = bus.bus_gnt && state inside {WR0, WR1, WR2};
    bus.mem_addr  = state == LDPAT ? AW'(PAT_ADDR) :
                    state == SCAN  ? AW'(idx) :
                    state == WR0   ? AW'(RES_ADDR) :
                    state == WR1   ? AW'(RES_ADDR + 1) :
                    state == WR2   ? AW'(RES_ADDR + 2) : '0;
    bus.mem_wdata = state == WR0 ? ctb : state == WR1 ? cto : state == WR2 ? cts : '0;
  end
  // windows 0..3 lie inside the current byte; 4..7 straddle the previous byte's low nibble
  always_comb begin
    in_hits = '0;
    x_hits  = '0;
    for (int i = 0; i < 4; i++) in_hits = in_hits + 3'(bus.mem_rdata[i +: 5] == pat);
    for (int i = 0; i < 8; i++) x_hits = x_hits + 4'(w[i +: 5] == pat);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pat   <= '0;
      idx   <= '0;
      prev4 <= '0;
      ctb   <= '0;
      cto   <= '0;
      cts   <= '0;
    end else if (go) begin
      idx <= '0;
      ctb <= '0;
      cto <= '0;
      cts <= '0;
    end else if (bus.bus_gnt && state == LDPAT) begin
      pat <= bus.mem_rdata[7:3];
      idx <= '0;
    end else if (bus.bus_gnt && state == SCAN) begin
      ctb   <= ctb + 8'(in_hits);
      cto   <= cto + 8'(in_hits != 3'd0);
      cts   <= cts + (idx == '0 ? 8'(in_hits) : 8'(x_hits));
      prev4 <= bus.mem_rdata[3:0];
      idx   <= idx + 1'b1;
    end
endmodule
